cam_frame_capture: RTL and testbench
====================================

# cam_frame_capture

Captures pixels from an 8-bit DVP camera port (RGB565, two bytes per pixel, 640×480 active), decimates 2:1 in both axes, reduces each pixel to 3-bit {R,G,B}, and writes it into the 320×240 frame buffer. The buffer address is row-major (row·320 + col), the same layout the VGA display path reads from. The block is the writer end of that frame buffer and sits between the camera pins and the buffer's write port. It runs entirely on the system clock and oversamples the camera's pixel clock.

## Interface
Parameters:
- `SRC_W`, 640: active source pixels per line.
- `SRC_H`, 480: active source lines per frame.
- `IMG_W`, 320: stored image width (= `SRC_W`/2).
- `IMG_H`, 240: stored image height (= `SRC_H`/2).
- `ADDR_W`, 18: frame buffer address width.

Ports:
- `clk`  in  1: system clock, 25 MHz. The single clock of the block.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cam_pclk`  in  1: camera pixel clock, asynchronous. Treated as data and must be ≤ clk/4.
- `cam_vsync`  in  1: high during vertical blanking.
- `cam_href`  in  1: high during active line bytes.
- `cam_data`  in  8: DVP data byte.
- `capture_en`  in  1: level; enables frame capture.
- `wr_en`  out  1: one-cycle write strobe.
- `wr_addr`  out  `ADDR_W`: write address.
- `wr_data`  out  3: pixel {R,G,B}.
- `frame_done`  out  1: one-cycle pulse at the end of each captured frame.
- `busy`  out  1: high in ARMED or ACTIVE.

## Operation
- **Input sync:** `cam_pclk`, `cam_vsync`, `cam_href` and `cam_data` pass through 2 flops, then a third flop on `cam_pclk` for edge detection.
  - `pe` (pclk rising edge) = sync2 & ~sync3. All camera-side events qualify on `pe`.
  - `cam_vsync` edges are detected on the synchronized value.
- **FSM:**
  - IDLE: wait for `capture_en`=1, then go to ARMED.
  - ARMED: wait for a synchronized `cam_vsync` falling edge, which is the start of frame. Then go to ACTIVE and clear `row`, `col` and the byte phase.
  - ACTIVE: capture pixels. A `cam_vsync` rising edge goes to DONE.
  - DONE: assert `frame_done` for one cycle. Go to ARMED if `capture_en`=1, else IDLE.
- **Byte pairing:** on `pe` with href=1, phase 0 latches `hi`=data; phase 1 forms the pixel from {`hi`, data} and toggles back to phase 0.
- **Pixel reduction:** R=`hi[7]`, G=`hi[2]`, B=`data[4]`. These are the MSBs of R5, G6 and B5.
- **Counters:**
  - `col` increments once per completed pixel and is cleared on the href falling edge.
  - `row` increments on each href falling edge that follows ≥1 byte in the line.
  - Both counters saturate; they do not wrap.
- **Write condition:** `col[0]`=0, `row[0]`=0, `col`<`SRC_W`, `row`<`SRC_H`.
  - `wr_addr` = (`row`>>1)·`IMG_W` + (`col`>>1).
  - Maintain `wr_addr` with an incremental line-base register. No multiplier is allowed.
  - Maximum address is 76799 and must never be exceeded.
- **Boundaries:**
  - Odd byte count in a line: the trailing byte is discarded and the phase is reset on the href falling edge.
  - Extra pixels per line or extra lines per frame: ignored, with no write.
  - `cam_vsync` rising mid-line: end the frame normally.
  - `capture_en` falling mid-frame: finish the current frame, then go to IDLE.
  - href while in ARMED or IDLE: ignored.
  - `reset_n` low mid-frame: immediate return to IDLE. No `frame_done` pulse and no write.
- **Reset values:** `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `busy`=0. FSM in IDLE, all counters at 0.

## Timing
- `wr_en`, `wr_addr` and `wr_data` are registered and valid together. They assert 4 clk after the `cam_pclk` rising edge of the second byte reaches the input pins: 2 sync stages, 1 edge-detect stage, 1 output register.
- `wr_addr`/`wr_data` hold their last values when `wr_en`=0.
- `frame_done` asserts 4 clk after the `cam_vsync` rise at the pins.
- `busy` deasserts in the same cycle that `frame_done` pulses, when the next state is IDLE.
- At most one write per 4 clk, since pclk ≤ clk/4. No back-pressure: the frame buffer accepts every strobe.

## Structure
- Shared package `cam_pkg`:
  - FSM state enum `cap_state_t` (IDLE, ARMED, ACTIVE, DONE).
  - Constants `SRC_W`, `SRC_H`, `IMG_W`, `IMG_H`.
  - Function `rgb565_to_rgb3`.
- One sub-module `dvp_sync`: the 2-flop synchronizers plus edge detect. Outputs `pe`, `href_fall`, `vs_rise`, `vs_fall`, and synchronized data.
- Capture FSM, counters and address generation stay in the top module.

## Test plan
- One 640×480 frame, all pixels 0xF800 (red), pclk=clk/4 → 76800 writes, addresses 0..76799 each exactly once, `wr_data`=3'b100, one `frame_done`.
- Pixel (col 2, row 4) = 0x07E0, all others 0x0000 → single nonzero write: `wr_addr`=2·320+1=641, `wr_data`=3'b010.
- Line with 1281 bytes, then a frame with 500 lines → trailing byte dropped; the next line's first pixel pairs correctly; no write with address ≥76800.
- `capture_en` dropped at row 100 → frame completes, `frame_done` pulses, FSM returns to IDLE, no writes during the next frame.
- `reset_n` low for 3 clk at row 50 → all outputs 0 immediately, no `frame_done`. After release with `capture_en`=1, capture resumes at the next `cam_vsync` falling edge starting at address 0.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types, geometry constants and pixel reduction for the camera capture path
`timescale 1ns/1ps
package cam_pkg;

    localparam int SRC_W = 640;
    localparam int SRC_H = 480;
    localparam int IMG_W = 320;
    localparam int IMG_H = 240;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        DONE
    } cap_state_t;

    // Keep only the MSB of each RGB565 channel: R5[4], G6[5], B5[4]
    function automatic logic [2:0] rgb565_to_rgb3(input logic [15:0] px);
        return {px[15], px[10], px[4]};
    endfunction

endpackage

// File: rtl/dvp_sync.sv
// rtl/dvp_sync.sv - two-flop synchronizers and edge detection for the DVP camera pins
`timescale 1ns/1ps
module dvp_sync (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       pe,
    output logic       href_fall,
    output logic       vs_rise,
    output logic       vs_fall,
    output logic       href,
    output logic [7:0] data
);

    // bit 0 = first sync flop, bit 1 = second sync flop, bit 2 = edge-detect history
    logic [2:0] r_pclk_sync;
    logic [2:0] r_vs_sync;
    logic [2:0] r_href_sync;
    logic [7:0] r_data_s1;
    logic [7:0] r_data_s2;

    // Synchronizer chains; the edge-detect stage is registered so every output lines up one cycle after sync2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pclk_sync <= '0;
            r_vs_sync   <= '0;
            r_href_sync <= '0;
            r_data_s1   <= '0;
            r_data_s2   <= '0;
            pe          <= 1'b0;
            href_fall   <= 1'b0;
            vs_rise     <= 1'b0;
            vs_fall     <= 1'b0;
            href        <= 1'b0;
            data        <= '0;
        end else begin
            r_pclk_sync <= {r_pclk_sync[1:0], cam_pclk};
            r_vs_sync   <= {r_vs_sync[1:0], cam_vsync};
            r_href_sync <= {r_href_sync[1:0], cam_href};
            r_data_s1   <= cam_data;
            r_data_s2   <= r_data_s1;
            pe          <= r_pclk_sync[1] & ~r_pclk_sync[2];
            href_fall   <= ~r_href_sync[1] & r_href_sync[2];
            vs_rise     <= r_vs_sync[1] & ~r_vs_sync[2];
            vs_fall     <= ~r_vs_sync[1] & r_vs_sync[2];
            href        <= r_href_sync[1];
            data        <= r_data_s2;
        end
    end

endmodule

// File: rtl/cam_frame_capture.sv
// rtl/cam_frame_capture.sv - DVP RGB565 capture, 2:1 decimation, 3-bit reduction, frame buffer writer
`timescale 1ns/1ps
module cam_frame_capture #(
    parameter int SRC_W  = cam_pkg::SRC_W,
    parameter int SRC_H  = cam_pkg::SRC_H,
    parameter int IMG_W  = cam_pkg::IMG_W,
    parameter int IMG_H  = cam_pkg::IMG_H,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_done,
    output logic              busy
);
    import cam_pkg::*;

    // One spare bit so the counters can saturate past the active area instead of wrapping into it
    localparam int CW = $clog2(SRC_W) + 1;
    localparam int RW = $clog2(SRC_H) + 1;
    localparam logic [CW-1:0]     COL_LIM  = CW'(SRC_W);
    localparam logic [CW-1:0]     COL_MAX  = '1;
    localparam logic [RW-1:0]     ROW_LIM  = RW'(SRC_H);
    localparam logic [RW-1:0]     ROW_MAX  = '1;
    localparam logic [RW-1:0]     BASE_END = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(IMG_W);

    logic       w_pe;
    logic       w_href_fall;
    logic       w_vs_rise;
    logic       w_vs_fall;
    logic       w_href;
    logic [7:0] w_data;

    dvp_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .pe        (w_pe),
        .href_fall (w_href_fall),
        .vs_rise   (w_vs_rise),
        .vs_fall   (w_vs_fall),
        .href      (w_href),
        .data      (w_data)
    );

    cap_state_t        r_state;
    cap_state_t        w_next;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_phase;
    logic              r_seen;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [2:0]        r_wr_data;

    logic w_active;
    logic w_start;
    logic w_byte0;
    logic w_pix;
    logic w_line_end;
    logic w_wr_ok;

    assign w_active   = (r_state == ACTIVE);
    assign w_start    = (r_state == ARMED) && w_vs_fall;
    assign w_byte0    = w_active && w_pe && w_href && !r_phase;
    assign w_pix      = w_active && w_pe && w_href && r_phase;
    assign w_line_end = w_active && w_href_fall;
    assign w_wr_ok    = !r_col[0] && !r_row[0] && (r_col < COL_LIM) && (r_row < ROW_LIM);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: arm on enable, start on vsync fall, end on vsync rise, pulse DONE once
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (capture_en) w_next = ARMED;
            ARMED:   if (w_vs_fall)  w_next = ACTIVE;
            ACTIVE:  if (w_vs_rise)  w_next = DONE;
            DONE:    w_next = capture_en ? ARMED : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Byte pairing, saturating row/col counters, line-base address tracking and the write register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_phase     <= 1'b0;
            r_seen      <= 1'b0;
            r_hi        <= '0;
            r_line_base <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_col       <= '0;
                r_row       <= '0;
                r_phase     <= 1'b0;
                r_seen      <= 1'b0;
                r_line_base <= '0;
            end else if (w_byte0) begin
                r_hi    <= w_data;
                r_phase <= 1'b1;
                r_seen  <= 1'b1;
            end else if (w_pix) begin
                r_phase <= 1'b0;
                if (r_col != COL_MAX) r_col <= r_col + CW'(1);
                if (w_wr_ok) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_line_base + ADDR_W'(r_col >> 1);
                    r_wr_data <= rgb565_to_rgb3({r_hi, w_data});
                end
            end else if (w_line_end) begin
                // A dangling odd byte is dropped here by forcing the phase back to the high byte
                r_col   <= '0;
                r_phase <= 1'b0;
                r_seen  <= 1'b0;
                if (r_seen) begin
                    if (r_row != ROW_MAX) r_row <= r_row + RW'(1);
                    // Stored row advances only when leaving an odd source row; stop at the last stored row
                    if (r_row[0] && ((r_row >> 1) < BASE_END)) r_line_base <= r_line_base + LINE_INC;
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = (r_state == DONE);
    assign busy       = (r_state == ARMED) || (r_state == ACTIVE) || ((r_state == DONE) && capture_en);

endmodule

// File: tb/tb_cam_frame_capture.sv
// tb/tb_cam_frame_capture.sv - randomized self-checking bench for cam_frame_capture on a reduced frame size
`timescale 1ns/1ps
module tb_cam_frame_capture;

    localparam int CLK_P = 10;
    localparam int SW = 16;
    localparam int SH = 12;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int AW = 18;
    // Pins change at a falling edge, so four rising edges later is 3.5 clk; sampling adds 1 ns
    localparam int LAT = 4 * CLK_P - CLK_P / 2 + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          capture_en = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          frame_done;
    logic          busy;

    always #(CLK_P / 2) clk = ~clk;

    cam_frame_capture #(
        .SRC_W (SW),
        .SRC_H (SH),
        .IMG_W (IW),
        .IMG_H (IH),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .capture_en (capture_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    int checks = 0;
    int passes = 0;

    logic [7:0] fb[$];
    int lens[$];
    int exp_addr[$];
    int exp_data[$];
    int obs_addr[$];
    int obs_data[$];
    int obs_lat[$];
    int done_cnt = 0;
    int done_lat = 0;
    int cur_line = -1;
    time t_pclk_rise = 0;
    time t_vs_rise = 0;

    // Write/frame_done monitor, sampled 1 ns after each rising edge
    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            obs_addr.push_back(int'(wr_addr));
            obs_data.push_back(int'(wr_data));
            obs_lat.push_back(int'($time - t_pclk_rise));
        end
        if (frame_done) begin
            done_cnt++;
            done_lat = int'($time - t_vs_rise);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One camera byte period: 2 clk low (data/href/vsync change), 2 clk high
    task automatic pclk_cycle(input logic [7:0] d, input logic h, input logic v);
        @(negedge clk);
        cam_pclk = 1'b0;
        cam_data = d;
        cam_href = h;
        if (v && !cam_vsync) t_vs_rise = $time;
        cam_vsync = v;
        @(negedge clk);
        @(negedge clk);
        cam_pclk = 1'b1;
        t_pclk_rise = $time;
        @(negedge clk);
    endtask

    task automatic drive_frame(input int drop_row);
        int idx = 0;
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b1);
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b0);
        for (int l = 0; l < lens.size(); l++) begin
            cur_line = l;
            if (l == drop_row) capture_en = 1'b0;
            for (int b = 0; b < lens[l]; b++) begin
                pclk_cycle(fb[idx], 1'b1, 1'b0);
                idx++;
            end
            repeat (2) pclk_cycle(8'h00, 1'b0, 1'b0);
        end
        cur_line = -1;
        repeat (4) pclk_cycle(8'h00, 1'b0, 1'b1);
    endtask

    // Reference: pair bytes per line, keep even pixels of even lines inside the source window
    function automatic void build_expected(input int max_lines);
        int idx = 0;
        int row = 0;
        exp_addr.delete();
        exp_data.delete();
        for (int l = 0; l < lens.size(); l++) begin
            if (l < max_lines) begin
                for (int p = 0; p < lens[l] / 2; p++) begin
                    logic [15:0] px;
                    px = {fb[idx + 2 * p], fb[idx + 2 * p + 1]};
                    if ((p % 2 == 0) && (row % 2 == 0) && (p < SW) && (row < SH)) begin
                        exp_addr.push_back((row / 2) * IW + p / 2);
                        exp_data.push_back(int'({px[15], px[10], px[4]}));
                    end
                end
            end
            idx += lens[l];
            if (lens[l] >= 1) row++;
        end
    endfunction

    function automatic void make_uniform(input int nlines, input int nbytes, input logic [7:0] hi, input logic [7:0] lo);
        fb.delete();
        lens.delete();
        for (int l = 0; l < nlines; l++) begin
            lens.push_back(nbytes);
            for (int b = 0; b < nbytes; b++) fb.push_back((b % 2 == 0) ? hi : lo);
        end
    endfunction

    function automatic void clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_lat.delete();
        done_cnt = 0;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else passes++;
        checks++; if (wr_addr !== '0) $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); else passes++;
        checks++; if (wr_data !== 3'b000) $display("FAIL reset_wr_data: got %b want 000", wr_data); else passes++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_frame();
        int hits[IW * IH];
        capture_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL armed_busy: got %b want 1", busy); else passes++;
        make_uniform(SH, 2 * SW, 8'hF8, 8'h00);
        clear_obs();
        drive_frame(-1);
        for (int a = 0; a < IW * IH; a++) hits[a] = 0;
        for (int i = 0; i < obs_addr.size(); i++) begin
            if (obs_addr[i] >= 0 && obs_addr[i] < IW * IH) hits[obs_addr[i]]++;
            checks++; if (obs_data[i] !== 3'b100) $display("FAIL full_data[%0d]: got %0d want 4", i, obs_data[i]); else passes++;
        end
        checks++; if (obs_addr.size() !== IW * IH) $display("FAIL full_count: got %0d want %0d", obs_addr.size(), IW * IH); else passes++;
        for (int a = 0; a < IW * IH; a++) begin
            checks++; if (hits[a] !== 1) $display("FAIL full_addr_once[%0d]: got %0d want 1", a, hits[a]); else passes++;
        end
        checks++; if (done_cnt !== 1) $display("FAIL full_frame_done: got %0d want 1", done_cnt); else passes++;
        checks++; if (obs_lat.size() == 0 || obs_lat[0] !== LAT) $display("FAIL write_latency: got %0d want %0d", (obs_lat.size() == 0) ? -1 : obs_lat[0], LAT); else passes++;
        checks++; if (done_lat !== LAT) $display("FAIL done_latency: got %0d want %0d", done_lat, LAT); else passes++;
    endtask

    task automatic test_single_pixel();
        int nz = 0;
        int nz_addr = -1;
        int nz_data = -1;
        make_uniform(SH, 2 * SW, 8'h00, 8'h00);
        fb[4 * 2 * SW + 4] = 8'h07;
        fb[4 * 2 * SW + 5] = 8'hE0;
        build_expected(SH + 100);
        clear_obs();
        drive_frame(-1);
        for (int i = 0; i < obs_data.size(); i++) begin
            if (obs_data[i] != 0) begin
                nz++;
                nz_addr = obs_addr[i];
                nz_data = obs_data[i];
            end
        end
        checks++; if (nz !== 1) $display("FAIL single_nonzero_count: got %0d want 1", nz); else passes++;
        checks++; if (nz_addr !== 2 * IW + 1) $display("FAIL single_addr: got %0d want %0d", nz_addr, 2 * IW + 1); else passes++;
        checks++; if (nz_data !== 3'b010) $display("FAIL single_data: got %0d want 2", nz_data); else passes++;
        checks++; if (obs_addr.size() !== exp_addr.size()) $display("FAIL single_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); else passes++;
    endtask

    task automatic test_odd_and_extra();
        int max_addr = -1;
        fb.delete();
        lens.delete();
        for (int l = 0; l < SH + 4; l++) begin
            int n;
            case ($urandom_range(0, 3))
                0: n = 2 * SW;
                1: n = 2 * SW + 1;
                2: n = 2 * SW + 6;
                default: n = $urandom_range(1, 2 * SW + 3);
            endcase
            if (l == 0) n = 2 * SW + 1;
            lens.push_back(n);
            for (int b = 0; b < n; b++) fb.push_back(8'($urandom));
        end
        build_expected(SH + 100);
        clear_obs();
        drive_frame(-1);
        checks++; if (obs_addr.size() !== exp_addr.size()) $display("FAIL rand_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); else passes++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL rand_write[%0d]: got addr %0d data %0d want addr %0d data %0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else passes++;
        end
        for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] > max_addr) max_addr = obs_addr[i];
        checks++; if (max_addr >= IW * IH) $display("FAIL rand_addr_bound: got %0d want < %0d", max_addr, IW * IH); else passes++;
        checks++; if (done_cnt !== 1) $display("FAIL rand_frame_done: got %0d want 1", done_cnt); else passes++;
    endtask

    task automatic test_capture_drop();
        make_uniform(SH, 2 * SW, 8'h84, 8'h10);
        for (int i = 0; i < fb.size(); i++) fb[i] = 8'($urandom);
        build_expected(SH + 100);
        clear_obs();
        drive_frame(3);
        checks++; if (obs_addr.size() !== exp_addr.size()) $display("FAIL drop_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); else passes++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL drop_write[%0d]: got addr %0d data %0d want addr %0d data %0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else passes++;
        end
        checks++; if (done_cnt !== 1) $display("FAIL drop_frame_done: got %0d want 1", done_cnt); else passes++;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL drop_idle_busy: got %b want 0", busy); else passes++;
        clear_obs();
        drive_frame(-1);
        checks++; if (obs_addr.size() !== 0) $display("FAIL idle_writes: got %0d want 0", obs_addr.size()); else passes++;
        checks++; if (done_cnt !== 0) $display("FAIL idle_frame_done: got %0d want 0", done_cnt); else passes++;
    endtask

    task automatic test_reset_midframe();
        capture_en = 1'b1;
        make_uniform(SH, 2 * SW, 8'h00, 8'h00);
        for (int i = 0; i < fb.size(); i++) fb[i] = 8'($urandom);
        build_expected(2);
        clear_obs();
        fork
            drive_frame(-1);
            begin
                int k = 0;
                while (cur_line != 2 && k < 20000) begin
                    @(negedge clk);
                    k++;
                end
                checks++; if (cur_line !== 2) $display("FAIL reset_wait: got line %0d want 2", cur_line); else passes++;
                reset_n = 1'b0;
                #1;
                checks++; if (wr_addr !== '0) $display("FAIL mid_reset_addr: got %0d want 0", wr_addr); else passes++;
                checks++; if (wr_data !== 3'b000) $display("FAIL mid_reset_data: got %0d want 0", wr_data); else passes++;
                checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else passes++;
                checks++; if (wr_en !== 1'b0 || frame_done !== 1'b0) $display("FAIL mid_reset_strobes: got %b%b want 00", wr_en, frame_done); else passes++;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
            end
        join
        checks++; if (done_cnt !== 0) $display("FAIL mid_reset_done: got %0d want 0", done_cnt); else passes++;
        checks++; if (obs_addr.size() !== exp_addr.size()) $display("FAIL mid_reset_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); else passes++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL mid_reset_write[%0d]: got addr %0d data %0d want addr %0d data %0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else passes++;
        end
        build_expected(SH + 100);
        clear_obs();
        drive_frame(-1);
        checks++; if (obs_addr.size() == 0 || obs_addr[0] !== 0) $display("FAIL resume_first_addr: got %0d want 0", (obs_addr.size() == 0) ? -1 : obs_addr[0]); else passes++;
        checks++; if (obs_addr.size() !== exp_addr.size()) $display("FAIL resume_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); else passes++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL resume_write[%0d]: got addr %0d data %0d want addr %0d data %0d", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            else passes++;
        end
        checks++; if (done_cnt !== 1) $display("FAIL resume_frame_done: got %0d want 1", done_cnt); else passes++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_single_pixel();
        test_odd_and_extra();
        test_capture_drop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
